regbank_reader: RTL

//  Bank of DEPTH WIDTH-bit enable-registers with a write port and a streaming read-out engine.
//  On start, entries base..base+count-1 are streamed out over a valid/ready handshake.

---
 rtl/regbank_pkg.sv | 13 +
 rtl/regbank_reader_if.sv | 47 ++++
 rtl/regbank_reader_register.sv | 17 +
 rtl/regbank_reader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank reader: FSM state encoding and address-width helper.
package regbank_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regbank_reader_if.sv
// Writer/stream-out signal bundle for regbank_reader.
// Defining REGBANK_PARITY_EN adds the rparity beat signal.
interface regbank_reader_if
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = calc_aw(DEPTH);

  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             rvalid;
  logic             rready;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    raddr;
`ifdef REGBANK_PARITY_EN
  logic             rparity;

  modport master (
    output wen, waddr, wdata, start, base, count, rready,
    input  busy, done, rvalid, rdata, raddr, rparity
  );

  modport slave (
    input  wen, waddr, wdata, start, base, count, rready,
    output busy, done, rvalid, rdata, raddr, rparity
  );
`else
  modport master (
    output wen, waddr, wdata, start, base, count, rready,
    input  busy, done, rvalid, rdata, raddr
  );

  modport slave (
    input  wen, waddr, wdata, start, base, count, rready,
    output busy, done, rvalid, rdata, raddr
  );
`endif

endinterface

// File: rtl/regbank_reader_register.sv
// Plain enable register holding one bank entry; deliberately has no reset.
module regbank_reader_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regbank_reader.sv
// Register bank with a write port and a valid/ready streaming read-out engine.
// Optional REGBANK_PARITY_EN adds a registered even-parity bit alongside rdata.
module regbank_reader
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  regbank_reader_if.slave bus
);

  localparam int unsigned AW = calc_aw(DEPTH);

  logic [WIDTH-1:0] bank [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    regbank_reader_register #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk (clk),
      .en  (bus.wen && (bus.waddr == AW'(i))),
      .d   (bus.wdata),
      .q   (bank[i])
    );
  end

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      remain_q, remain_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic             fetch;
  logic             fire;

  assign fire = rvalid_q && bus.rready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    fetch    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StLoad;
            ptr_d    = bus.base;
            remain_d = bus.count;
          end
        end
      end
      StLoad: begin
        fetch   = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (fire) begin
          if (remain_q == '0) begin
            rvalid_d = 1'b0;
            state_d  = StDone;
          end else begin
            fetch = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Bank read is combinational, so a same-edge write is not yet visible here.
    if (fetch) begin
      rdata_d  = bank[ptr_q];
      raddr_d  = ptr_q;
      rvalid_d = 1'b1;
      ptr_d    = ptr_q + AW'(1);
      remain_d = remain_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      remain_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
    end
  end

`ifdef REGBANK_PARITY_EN
  logic rparity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rparity_q <= 1'b0;
    end else begin
      rparity_q <= ^rdata_d;
    end
  end

  assign bus.rparity = rparity_q;
`endif

  assign bus.busy   = (state_q == StLoad) || (state_q == StStream);
  assign bus.done   = (state_q == StDone);
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.raddr  = raddr_q;

endmodule
